decoder_sys: RTL and testbench

//  Rate-1/2 hard-decision Viterbi decoder with run-time selectable constraint length K=3..7.

---
 rtl/decoder_pkg.sv | 50 +++++
 rtl/decoder_acs.sv | 32 +++
 rtl/decoder_sys.sv | 114 +++++++++++
 tb/tb_decoder_sys.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and trellis helpers for the rate-1/2 Viterbi decoder.
//   MAX_K / MAX_STATES : largest constraint length and its state count
//   TB_DEPTH           : survivor length, equal to the decode latency
//   PM_W               : path-metric width
// Helpers: generator lookup, K-select decode, expected symbol per branch,
// Hamming branch metric.
package decoder_pkg;

  localparam int MAX_K      = 7;
  localparam int MAX_STATES = 64;
  localparam int TB_DEPTH   = 15;
  localparam int PM_W       = 8;

  localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};

  // {G0, G1}, 7 bits each; bit K-1 taps the current input.
  function automatic logic [13:0] gen_poly(input logic [2:0] k);
    case (k)
      3'd3:    gen_poly = {7'o7, 7'o5};
      3'd4:    gen_poly = {7'o17, 7'o15};
      3'd5:    gen_poly = {7'o23, 7'o35};
      3'd6:    gen_poly = {7'o53, 7'o75};
      default: gen_poly = {7'o171, 7'o133};
    endcase
  endfunction

  function automatic logic [2:0] k_decode(input logic [2:0] sel);
    k_decode = (sel < 3'd3) ? 3'd3 : sel;
  endfunction

  // Encoder register is {input, state}: state MSB is the newest past input.
  function automatic logic [1:0] expected_pair(input logic [2:0] k,
                                               input logic [5:0] state,
                                               input logic       in_bit);
    logic [13:0] g;
    logic [6:0]  r;
    g = gen_poly(k);
    r = {1'b0, state} | (7'(in_bit) << (k - 3'd1));
    expected_pair = {^(r & g[13:7]), ^(r & g[6:0])};
  endfunction

  function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                               input logic [1:0] ref_pair);
    logic [1:0] d;
    d = rx ^ ref_pair;
    branch_metric = {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/decoder_acs.sv
// One add-compare-select cell.
//   pm_a, pm_b : metrics of the lower- and higher-index predecessor
//   bm_a, bm_b : branch metrics of the two incoming branches
//   pm_new     : saturated surviving metric
//   dec        : 1 when the higher-index predecessor wins
module decoder_acs
  import decoder_pkg::*;
(
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W:0]   sum_a;
  logic [PM_W:0]   sum_b;
  logic [PM_W-1:0] sat_a;
  logic [PM_W-1:0] sat_b;

  always_comb begin
    sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
    sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
    sat_a  = sum_a[PM_W] ? PM_MAX : sum_a[PM_W-1:0];
    sat_b  = sum_b[PM_W] ? PM_MAX : sum_b[PM_W-1:0];
    // Strict compare: on a tie the lower-index predecessor keeps the path.
    dec    = (sat_b < sat_a);
    pm_new = dec ? sat_b : sat_a;
  end

endmodule

// File: rtl/decoder_sys.sv
// Rate-1/2 hard-decision Viterbi decoder, K = 3..7, register-exchange
// survivors, fixed decode latency TB_DEPTH.
//   clk                      : clock
//   rst_n                    : synchronous active-low reset
//   encoded_bits             : one symbol per cycle, [1]=G0, [0]=G1
//   choose_constraint_length : K select (0..2 behave as 3)
//   final_output             : registered decoded bit
module decoder_sys
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] encoded_bits,
  input  logic [2:0] choose_constraint_length,
  output logic       final_output
);

  logic [2:0]          k_q;
  logic [2:0]          k_sel;
  logic                clear;
  logic [6:0]          n_states;
  logic [5:0]          st_mask;
  logic [PM_W-1:0]     pm_q     [MAX_STATES];
  logic [TB_DEPTH-1:0] surv_q   [MAX_STATES];
  logic [5:0]          pred0    [MAX_STATES];
  logic                in_bit   [MAX_STATES];
  logic [PM_W-1:0]     pm_a     [MAX_STATES];
  logic [PM_W-1:0]     pm_b     [MAX_STATES];
  logic [1:0]          bm_a     [MAX_STATES];
  logic [1:0]          bm_b     [MAX_STATES];
  logic [PM_W-1:0]     acs_pm   [MAX_STATES];
  logic                acs_dec  [MAX_STATES];
  logic [PM_W-1:0]     pm_nxt   [MAX_STATES];
  logic [TB_DEPTH-1:0] surv_win [MAX_STATES];
  logic [TB_DEPTH-1:0] surv_nxt [MAX_STATES];
  logic                all_msb;
  logic [5:0]          best;
  logic [PM_W-1:0]     best_pm;

  // A change of effective K restarts the decoder exactly like a reset.
  assign k_sel    = k_decode(choose_constraint_length);
  assign clear    = !rst_n || (k_sel != k_q);
  assign n_states = 7'd1 << (k_q - 3'd1);
  assign st_mask  = 6'(n_states - 7'd1);

  // New state s' = {u, s[K-2:1]}: predecessors are {s'[K-3:0], 0/1},
  // and the input bit of the branch is the MSB of s'.
  always_comb begin
    for (int s = 0; s < MAX_STATES; s++) begin
      pred0[s]  = 6'(s << 1) & st_mask;
      in_bit[s] = 1'(s >> (k_q - 3'd2));
      pm_a[s]   = pm_q[pred0[s]];
      pm_b[s]   = pm_q[pred0[s] | 6'd1];
      bm_a[s]   = branch_metric(encoded_bits, expected_pair(k_q, pred0[s], in_bit[s]));
      bm_b[s]   = branch_metric(encoded_bits, expected_pair(k_q, pred0[s] | 6'd1, in_bit[s]));
    end
  end

  for (genvar g = 0; g < MAX_STATES; g++) begin : g_acs
    decoder_acs u_acs (
      .pm_a   (pm_a[g]),
      .pm_b   (pm_b[g]),
      .bm_a   (bm_a[g]),
      .bm_b   (bm_b[g]),
      .pm_new (acs_pm[g]),
      .dec    (acs_dec[g])
    );
  end

  always_comb begin
    all_msb = 1'b1;
    for (int s = 0; s < MAX_STATES; s++) begin
      if (7'(s) < n_states && !acs_pm[s][PM_W-1]) all_msb = 1'b0;
    end
    for (int s = 0; s < MAX_STATES; s++) begin
      surv_win[s] = acs_dec[s] ? surv_q[pred0[s] | 6'd1] : surv_q[pred0[s]];
      if (7'(s) < n_states) begin
        pm_nxt[s]   = all_msb ? {1'b0, acs_pm[s][PM_W-2:0]} : acs_pm[s];
        surv_nxt[s] = {surv_win[s][TB_DEPTH-2:0], in_bit[s]};
      end else begin
        pm_nxt[s]   = PM_MAX;
        surv_nxt[s] = '0;
      end
    end
  end

  // Minimum metric, lowest index on a tie.
  always_comb begin
    best    = '0;
    best_pm = pm_q[0];
    for (int s = 1; s < MAX_STATES; s++) begin
      if (pm_q[s] < best_pm) begin
        best    = 6'(s);
        best_pm = pm_q[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      k_q          <= k_sel;
      final_output <= 1'b0;
      for (int s = 0; s < MAX_STATES; s++) begin
        pm_q[s]   <= (s == 0) ? {PM_W{1'b0}} : PM_INIT;
        surv_q[s] <= '0;
      end
    end else begin
      pm_q         <= pm_nxt;
      surv_q       <= surv_nxt;
      final_output <= surv_q[best][TB_DEPTH-1];
    end
  end

endmodule

// File: tb/tb_decoder_sys.sv
module tb_decoder_sys;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] encoded_bits;
  logic [2:0] choose_constraint_length;
  logic       final_output;

  int n_cmp = 0;
  int n_err = 0;
  bit msg [0:255];

  decoder_sys dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .encoded_bits             (encoded_bits),
    .choose_constraint_length (choose_constraint_length),
    .final_output             (final_output)
  );

  always #5 clk = ~clk;

  // Generator table in octal; which=0 gives G0, which=1 gives G1.
  function automatic int poly(input int k, input int which);
    case (k)
      3:       return (which == 0) ? 'o7   : 'o5;
      4:       return (which == 0) ? 'o17  : 'o15;
      5:       return (which == 0) ? 'o23  : 'o35;
      6:       return (which == 0) ? 'o53  : 'o75;
      default: return (which == 0) ? 'o171 : 'o133;
    endcase
  endfunction

  // Convolutional encoder over the message history: tap i of a generator
  // multiplies the input bit (K-1-i) steps in the past.
  function automatic logic [1:0] enc_sym(input int k, input int idx);
    int g0, g1, p0, p1, j;
    g0 = poly(k, 0);
    g1 = poly(k, 1);
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < k; i++) begin
      j = idx - (k - 1 - i);
      if (j >= 0 && msg[j]) begin
        p0 += (g0 >> i) & 1;
        p1 += (g1 >> i) & 1;
      end
    end
    return {p0[0], p1[0]};
  endfunction

  function automatic logic exp_bit(input int n);
    if (n >= 15) return msg[n-15];
    return 1'b0;
  endfunction

  task automatic load_msg(input int len);
    for (int i = 0; i < 256; i++) msg[i] = (i < len) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic drive(input logic [1:0] sym, output logic out);
    encoded_bits = sym;
    @(posedge clk);
    #1;
    out = final_output;
  endtask

  task automatic do_reset(input logic [2:0] sel);
    logic o;
    choose_constraint_length = sel;
    rst_n = 1'b0;
    drive(2'(($urandom)), o);
    drive(2'(($urandom)), o);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic o;
    choose_constraint_length = 3'd3;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'($urandom), o);
      n_cmp++;
      if (o !== 1'b0) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%b exp=0", i, o);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_k3_stream(input bit with_error);
    logic [1:0] syms [6];
    bit         bits [6];
    logic       o, e;
    syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    if (with_error) syms[2] = 2'b10;
    do_reset(3'd3);
    for (int n = 0; n < 30; n++) begin
      drive((n < 6) ? syms[n] : 2'b00, o);
      e = (n >= 15 && n < 21) ? bits[n-15] : 1'b0;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL k3_stream err=%0d n=%0d got=%b exp=%b", with_error, n, o, e);
      end
    end
  endtask

  task automatic test_all_zero;
    logic o;
    for (int k = 3; k <= 7; k++) begin
      do_reset(3'(k));
      for (int n = 0; n < 40; n++) begin
        drive(2'b00, o);
        n_cmp++;
        if (o !== 1'b0) begin
          n_err++;
          $display("FAIL all_zero k=%0d n=%0d got=%b exp=0", k, n, o);
        end
      end
    end
  endtask

  task automatic test_k7_random;
    logic o, e;
    load_msg(100);
    do_reset(3'd7);
    for (int n = 0; n < 120; n++) begin
      drive(enc_sym(7, n), o);
      e = exp_bit(n);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL k7_random n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  task automatic test_reset_midstream(input int at);
    logic o, e;
    load_msg(60);
    do_reset(3'd3);
    for (int n = 0; n < at; n++) begin
      drive(enc_sym(3, n), o);
      e = exp_bit(n);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_pre at=%0d n=%0d got=%b exp=%b", at, n, o, e);
      end
    end
    rst_n = 1'b0;
    drive(enc_sym(3, at), o);
    rst_n = 1'b1;
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst at=%0d got=%b exp=0", at, o);
    end
    load_msg(40);
    for (int n = 0; n < 60; n++) begin
      drive(enc_sym(3, n), o);
      e = exp_bit(n);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_fresh at=%0d n=%0d got=%b exp=%b", at, n, o, e);
      end
    end
  endtask

  task automatic test_k_change;
    logic o, e;
    load_msg(40);
    do_reset(3'd3);
    for (int n = 0; n < 25; n++) begin
      drive(enc_sym(3, n), o);
      e = exp_bit(n);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL kchg_k3 n=%0d got=%b exp=%b", n, o, e);
      end
    end
    choose_constraint_length = 3'd5;
    drive(2'($urandom), o);
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL kchg_to5 got=%b exp=0", o);
    end
    load_msg(60);
    for (int n = 0; n < 80; n++) begin
      drive(enc_sym(5, n), o);
      e = exp_bit(n);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL kchg_k5 n=%0d got=%b exp=%b", n, o, e);
      end
    end
    choose_constraint_length = 3'd0;
    drive(2'($urandom), o);
    n_cmp++;
    if (o !== 1'b0) begin
      n_err++;
      $display("FAIL kchg_to0 got=%b exp=0", o);
    end
    load_msg(50);
    for (int n = 0; n < 70; n++) begin
      drive(enc_sym(3, n), o);
      e = exp_bit(n);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL kchg_sel0 n=%0d got=%b exp=%b", n, o, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    encoded_bits = 2'b00;
    choose_constraint_length = 3'd3;
    test_reset();
    test_k3_stream(1'b0);
    test_k3_stream(1'b1);
    test_all_zero();
    test_k7_random();
    test_reset_midstream(8);
    test_reset_midstream(25);
    test_k_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
